// File: rtl/sparse_buffer_reader.sv
// Scans entries 0..len-1 of an activation buffer and emits them as a (value, index)
// valid/ready stream, optionally dropping zero entries.
module sparse_buffer_reader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_length,
  input  logic              i_skip_zero,
  output logic [ADDR_W-1:0] o_buf_address,
  output logic              o_buf_read_enable,
  input  logic [DATA_W-1:0] i_buf_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_index,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_nnz_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  state_t              r_state;
  logic [ADDR_W:0]     r_ptr;
  logic [ADDR_W:0]     r_len;
  logic                r_skip;
  logic [ADDR_W-1:0]   r_buf_address;
  logic                r_buf_read_enable;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_index;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W:0]     r_nnz;

  state_t              w_state_nxt;
  logic [ADDR_W:0]     w_ptr_nxt;
  logic [ADDR_W:0]     w_len_nxt;
  logic                w_skip_nxt;
  logic [ADDR_W:0]     w_nnz_nxt;
  logic                w_capture;
  logic [ADDR_W:0]     w_len_clamped;
  logic                w_last;

  assign w_len_clamped = (i_length > LP_DEPTH) ? LP_DEPTH : i_length;
  // ptr is one bit wider than the address so a full 64-entry scan never wraps
  assign w_last        = (r_ptr == r_len - LP_ONE);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_len_nxt   = r_len;
    w_skip_nxt  = r_skip;
    w_nnz_nxt   = r_nnz;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_len_nxt   = w_len_clamped;
          w_skip_nxt  = i_skip_zero;
          w_ptr_nxt   = '0;
          w_nnz_nxt   = '0;
          w_state_nxt = (w_len_clamped == '0) ? DONE : READ;
        end
      end
      READ: w_state_nxt = CHECK;
      CHECK: begin
        if (r_skip && (i_buf_data == '0)) begin
          w_ptr_nxt   = r_ptr + LP_ONE;
          w_state_nxt = w_last ? DONE : READ;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (r_out_valid && i_out_ready) begin
          w_nnz_nxt   = r_nnz + LP_ONE;
          w_ptr_nxt   = r_ptr + LP_ONE;
          w_state_nxt = w_last ? DONE : READ;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is valid in the cycle of its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= IDLE;
      r_ptr             <= '0;
      r_len             <= '0;
      r_skip            <= 1'b0;
      r_buf_address     <= '0;
      r_buf_read_enable <= 1'b0;
      r_out_valid       <= 1'b0;
      r_out_data        <= '0;
      r_out_index       <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_nnz             <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_ptr             <= w_ptr_nxt;
      r_len             <= w_len_nxt;
      r_skip            <= w_skip_nxt;
      r_nnz             <= w_nnz_nxt;
      r_buf_read_enable <= (w_state_nxt == READ);
      r_out_valid       <= (w_state_nxt == OUT);
      r_busy            <= (w_state_nxt != IDLE);
      r_done            <= (w_state_nxt == DONE);
      if (w_state_nxt == READ) r_buf_address <= w_ptr_nxt[ADDR_W-1:0];
      if (w_capture) begin
        r_out_data  <= i_buf_data;
        r_out_index <= r_ptr[ADDR_W-1:0];
      end
    end
  end

  assign o_buf_address     = r_buf_address;
  assign o_buf_read_enable = r_buf_read_enable;
  assign o_out_valid       = r_out_valid;
  assign o_out_data        = r_out_data;
  assign o_out_index       = r_out_index;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_nnz_count       = r_nnz;

endmodule

// File: tb/tb_sparse_buffer_reader.sv
// Bench for sparse_buffer_reader: a buffer memory model feeds the DUT and each scan's
// beats, counts and timing are compared with a queue-based reference of the scan.
module tb_sparse_buffer_reader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_start;
  logic [ADDR_W:0]   i_length;
  logic              i_skip_zero;
  logic [ADDR_W-1:0] o_buf_address;
  logic              o_buf_read_enable;
  logic [DATA_W-1:0] i_buf_data;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [DATA_W-1:0] o_out_data;
  logic [ADDR_W-1:0] o_out_index;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W:0]   o_nnz_count;

  logic [DATA_W-1:0] mem [DEPTH];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sparse_buffer_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_length(i_length),
    .i_skip_zero(i_skip_zero), .o_buf_address(o_buf_address),
    .o_buf_read_enable(o_buf_read_enable), .i_buf_data(i_buf_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_index(o_out_index), .o_busy(o_busy), .o_done(o_done), .o_nnz_count(o_nnz_count)
  );

  // Buffer: read data appears the cycle after the strobe and holds otherwise.
  always @(posedge clk) begin
    if (o_buf_read_enable) i_buf_data <= mem[o_buf_address];
  end

  task automatic fill_random(input int zero_pct);
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(99) < zero_pct) ? '0 : DATA_W'($urandom_range(65535, 1));
  endtask

  task automatic check_all_zero(input string name);
    logic [63:0] act;
    act = 64'({o_buf_address, o_buf_read_enable, o_out_valid, o_out_data, o_out_index,
               o_busy, o_done, o_nnz_count});
    checks++;
    if (act !== 64'd0) begin
      failures++;
      $display("FAIL %s: outputs=%h required all zero", name, act);
    end
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: 5-cycle stall on the first beat.
  task automatic run_scan(input int len_in, input bit skip, input int mode,
                          input bit spam_start, input string name);
    logic [DATA_W-1:0] ev[$];
    int ei[$];
    int len, n_exp, exp_cyc, stalls, cyc, stall_left, nbeats;
    bit seen_done, stall_armed, holding;
    logic [DATA_W-1:0] hold_d;
    logic [ADDR_W-1:0] hold_i;
    len = (len_in > DEPTH) ? DEPTH : len_in;
    for (int i = 0; i < len; i++)
      if (!(skip && mem[i] == '0)) begin
        ev.push_back(mem[i]);
        ei.push_back(i);
      end
    n_exp = ev.size();
    exp_cyc = 1 + 2 * (len - n_exp) + 3 * n_exp;
    stalls = 0; stall_left = 0; stall_armed = (mode == 2); holding = 0; seen_done = 0;
    nbeats = 0; hold_d = '0; hold_i = '0;
    i_length = (ADDR_W+1)'(len_in);
    i_skip_zero = skip;
    i_start = 1'b1;
    i_out_ready = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 1;
    checks++;
    if (o_buf_read_enable !== (len != 0) || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s first_cycle: rd_en=%b busy=%b required rd_en=%b busy=1",
               name, o_buf_read_enable, o_busy, (len != 0));
    end
    while (cyc <= 3000 && !seen_done) begin
      i_start = spam_start && !o_done;
      if (spam_start) begin
        i_length = (ADDR_W+1)'($urandom_range(127));
        i_skip_zero = 1'($urandom_range(1));
      end
      if (o_done) begin
        seen_done = 1;
        checks++;
        if (cyc != exp_cyc + stalls) begin
          failures++;
          $display("FAIL %s done_cycle: got=%0d required=%0d", name, cyc, exp_cyc + stalls);
        end
        checks++;
        if (o_nnz_count !== (ADDR_W+1)'(n_exp)) begin
          failures++;
          $display("FAIL %s nnz_count: got=%0d required=%0d", name, o_nnz_count, n_exp);
        end
      end else if (o_out_valid) begin
        checks++;
        if (int'(o_out_index) >= len || o_buf_read_enable !== 1'b0) begin
          failures++;
          $display("FAIL %s out_phase: index=%0d rd_en=%b required index<%0d rd_en=0",
                   name, o_out_index, o_buf_read_enable, len);
        end
        if (holding) begin
          checks++;
          if (o_out_data !== hold_d || o_out_index !== hold_i) begin
            failures++;
            $display("FAIL %s stall_hold: data=%h index=%0d required data=%h index=%0d",
                     name, o_out_data, o_out_index, hold_d, hold_i);
          end
        end
        if (stall_armed) begin
          stall_armed = 0;
          stall_left = 5;
        end
        case (mode)
          0:       i_out_ready = 1'b1;
          1:       i_out_ready = 1'($urandom_range(1));
          default: i_out_ready = (stall_left == 0);
        endcase
        if (stall_left > 0) stall_left--;
        if (i_out_ready) begin
          holding = 0;
          nbeats++;
          checks++;
          if (ev.size() == 0) begin
            failures++;
            $display("FAIL %s extra_beat: data=%h index=%0d required no beat",
                     name, o_out_data, o_out_index);
          end else begin
            if (o_out_data !== ev[0] || int'(o_out_index) != ei[0]) begin
              failures++;
              $display("FAIL %s beat%0d: data=%h index=%0d required data=%h index=%0d",
                       name, nbeats, o_out_data, o_out_index, ev[0], ei[0]);
            end
            void'(ev.pop_front());
            void'(ei.pop_front());
          end
        end else begin
          stalls++;
          holding = 1;
          hold_d = o_out_data;
          hold_i = o_out_index;
        end
      end else begin
        i_out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
    end else if (o_done !== 1'b0 || o_busy !== 1'b0 || ev.size() != 0) begin
      failures++;
      $display("FAIL %s end: done=%b busy=%b missing_beats=%0d required 0 0 0",
               name, o_done, o_busy, ev.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; i_length = '0; i_skip_zero = 1'b0; i_out_ready = 1'b0;
    i_buf_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    i_start = 1'b1; i_length = 7'd4;
    @(posedge clk); #1;
    check_all_zero("reset_beats_start");
    i_start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_dense();
    mem[0] = 16'd5; mem[1] = 16'd0; mem[2] = 16'd7; mem[3] = 16'd9;
    run_scan(4, 1'b0, 0, 1'b0, "dense");
  endtask

  task automatic test_sparse_skip();
    run_scan(4, 1'b1, 0, 1'b0, "sparse_skip");
  endtask

  task automatic test_backpressure();
    fill_random(30);
    run_scan(6, 1'b0, 2, 1'b0, "backpressure");
  endtask

  task automatic test_boundaries();
    run_scan(0, 1'b0, 0, 1'b0, "length0");
    fill_random(20);
    run_scan(100, 1'b0, 0, 1'b0, "clamp100");
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    run_scan(64, 1'b1, 0, 1'b0, "all_zero_skip");
  endtask

  task automatic test_restart_ignored();
    fill_random(40);
    run_scan(20, 1'b1, 1, 1'b1, "restart_spam");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      fill_random(int'($urandom_range(80)));
      run_scan(int'($urandom_range(127)), 1'($urandom_range(1)), 1, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    fill_random(0);
    i_length = 7'd10; i_skip_zero = 1'b0; i_out_ready = 1'b0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    n = 0;
    while (!o_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!o_out_valid) begin
      failures++;
      $display("FAIL reset_mid wait_valid: out_valid=%b required 1", o_out_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset_mid_scan");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all_zero("post_reset_quiet");
    end
    run_scan(10, 1'b0, 1, 1'b0, "after_reset_scan");
  endtask

  initial begin
    test_reset();
    test_dense();
    test_sparse_skip();
    test_backpressure();
    test_boundaries();
    test_restart_ignored();
    test_random();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
